// File: rtl/tim_hfsm_pkg.sv
// tim_hfsm_pkg: shared horizontal/vertical timing types and helpers.
// State enum, counter width and the pixel-window compare.
package tim_hfsm_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HD,
    ST_SHIFT,
    ST_DONE
  } hstate_t;

  // True when start <= p < start+len; one extra bit avoids wrap.
  function automatic logic in_win(
    input logic [CNT_W-1:0] p,
    input logic [CNT_W-1:0] start,
    input logic [CNT_W:0]   len
  );
    logic [CNT_W:0] pe;
    logic [CNT_W:0] se;
    pe = {1'b0, p};
    se = {1'b0, start};
    return (pe >= se) && (pe < se + len);
  endfunction

endpackage

// File: rtl/tim_hfsm_if.sv
// tim_hfsm_if: line request handshake plus AFE/CPU line controls.
// master = vertical FSM / consumers, slave = horizontal FSM.
interface tim_hfsm_if;
  import tim_hfsm_pkg::*;

  logic             line_req;
  logic             line_done;
  logic             busy;
  logic             ovf;
  logic             ccd_h1;
  logic             afe_hd;
  logic             afe_pblk;
  logic             afe_clpob;
  logic             afe_clpdm;
  logic             cpu_hsync;
  logic             pix_valid;
  logic [CNT_W-1:0] pix_x;

  modport master (
    output line_req,
    input  line_done, busy, ovf,
    input  ccd_h1, afe_hd, afe_pblk,
    input  afe_clpob, afe_clpdm,
    input  cpu_hsync, pix_valid, pix_x
  );

  modport slave (
    input  line_req,
    output line_done, busy, ovf,
    output ccd_h1, afe_hd, afe_pblk,
    output afe_clpob, afe_clpdm,
    output cpu_hsync, pix_valid, pix_x
  );

endinterface

// File: rtl/tim_hwin.sv
// tim_hwin: registered compare of a pixel index against START/LEN.
// Fed with next-cycle values so the flag lines up with ccd_h1.
module tim_hwin
  import tim_hfsm_pkg::*;
#(
  parameter int START = 0,
  parameter int LEN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] p,
  output logic             hit
);

  localparam logic [CNT_W-1:0] W_S = CNT_W'(START);
  localparam logic [CNT_W:0]   W_L = (CNT_W+1)'(LEN);

  // window flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= 1'b0;
    end else begin
      hit <= en && in_win(p, W_S, W_L);
    end
  end

endmodule

// File: rtl/tim_hfsm.sv
// tim_hfsm: horizontal line timing generator (HD, SHIFT, DONE).
// Optional dummy clamp window enabled by TIM_HFSM_CLPDM_EN.
module tim_hfsm
  import tim_hfsm_pkg::*;
#(
  parameter int H_PIX     = 1640,
  parameter int OB_START  = 4,
  parameter int OB_LEN    = 24,
  parameter int DM_START  = 0,
  parameter int DM_LEN    = 4,
  parameter int ACT_START = 32,
  parameter int ACT_LEN   = 1600
) (
  input logic       clk_pix,
  input logic       rst,
  tim_hfsm_if.slave hif
);

  if (OB_START + OB_LEN > H_PIX ||
      DM_START + DM_LEN > H_PIX ||
      ACT_START + ACT_LEN > H_PIX ||
      ACT_LEN > 4096 ||
      H_PIX > 2048 || H_PIX < 1) begin : g_cfg_err
    $fatal(1, "tim_hfsm: illegal window or size parameters");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*H_PIX-1);
  localparam logic [CNT_W-1:0] ACT_S    = CNT_W'(ACT_START);

  hstate_t          state;
  hstate_t          state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] p_n;
  logic             shift_n;
  logic             req_lost;

  // state and shift counter register
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next state and counter; requests accepted in IDLE/DONE only
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (hif.line_req) state_n = ST_HD;
      end
      ST_HD: begin
        state_n = ST_SHIFT;
        cnt_n   = '0;
      end
      ST_SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_n = ST_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_n = hif.line_req ? ST_HD : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign shift_n  = (state_n == ST_SHIFT);
  assign p_n      = {1'b0, cnt_n[CNT_W-1:1]};
  assign req_lost = hif.line_req &&
                    (state == ST_HD || state == ST_SHIFT);

  // outputs registered from next-state values: no extra latency
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      hif.ccd_h1    <= 1'b1;
      hif.afe_pblk  <= 1'b1;
      hif.afe_hd    <= 1'b0;
      hif.cpu_hsync <= 1'b0;
      hif.busy      <= 1'b0;
      hif.line_done <= 1'b0;
      hif.pix_x     <= '0;
      hif.ovf       <= 1'b0;
    end else begin
      hif.ccd_h1    <= !(shift_n && cnt_n[0]);
      hif.afe_pblk  <= !shift_n;
      hif.afe_hd    <= (state_n == ST_HD);
      hif.cpu_hsync <= (state_n == ST_HD);
      hif.busy      <= (state_n != ST_IDLE);
      hif.line_done <= (state_n == ST_DONE);
      hif.pix_x     <= shift_n ? p_n - ACT_S : '0;
      hif.ovf       <= hif.ovf | req_lost;
    end
  end

  tim_hwin #(
    .START (OB_START),
    .LEN   (OB_LEN)
  ) u_ob (
    .clk (clk_pix),
    .rst (rst),
    .en  (shift_n),
    .p   (p_n),
    .hit (hif.afe_clpob)
  );

  tim_hwin #(
    .START (ACT_START),
    .LEN   (ACT_LEN)
  ) u_act (
    .clk (clk_pix),
    .rst (rst),
    .en  (shift_n & cnt_n[0]),
    .p   (p_n),
    .hit (hif.pix_valid)
  );

`ifdef TIM_HFSM_CLPDM_EN
  tim_hwin #(
    .START (DM_START),
    .LEN   (DM_LEN)
  ) u_dm (
    .clk (clk_pix),
    .rst (rst),
    .en  (shift_n),
    .p   (p_n),
    .hit (hif.afe_clpdm)
  );
`else
  assign hif.afe_clpdm = 1'b0;
`endif

endmodule

// File: tb/tb_tim_hfsm.sv
// tb_tim_hfsm: directed vectors for tim_hfsm with H_PIX=16.
// Cycle 0 is the cycle in which the first line_req is driven.
module tb_tim_hfsm;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  tim_hfsm_if hif ();

  tim_hfsm #(
    .H_PIX     (16),
    .OB_START  (2),
    .OB_LEN    (3),
    .DM_START  (0),
    .DM_LEN    (2),
    .ACT_START (6),
    .ACT_LEN   (8)
  ) dut (
    .clk_pix (clk),
    .rst     (rst),
    .hif     (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {h1,hd,pblk,clpob,clpdm,hsync,pv,done,busy,ovf,pix_x}
  localparam logic [21:0] IDLE_W =
    {1'b1, 1'b0, 1'b1, 7'd0, 12'd0};

  function automatic logic [21:0] obs();
    logic [11:0] px;
    px = hif.pix_valid ? hif.pix_x : 12'd0;
    return {hif.ccd_h1, hif.afe_hd, hif.afe_pblk,
            hif.afe_clpob, hif.afe_clpdm, hif.cpu_hsync,
            hif.pix_valid, hif.line_done, hif.busy,
            hif.ovf, px};
  endfunction

  // rel = cycles since the line's request cycle
  function automatic logic [21:0] mdl(int rel, bit ovf);
    bit sh, odd, pv, dm;
    logic [11:0] px;
    sh  = rel >= 2 && rel <= 33;
    odd = (rel % 2) == 1;
    pv  = sh && odd && rel >= 15 && rel <= 29;
    px  = pv ? 12'((rel - 15) / 2) : 12'd0;
`ifdef TIM_HFSM_CLPDM_EN
    dm  = rel >= 2 && rel <= 5;
`else
    dm  = 1'b0;
`endif
    return {!(sh && odd), rel == 1, !sh,
            rel >= 6 && rel <= 11, dm, rel == 1,
            pv, rel == 34, rel >= 1 && rel <= 34,
            ovf, px};
  endfunction

  task automatic check(input string tag,
                       input logic [21:0] got,
                       input logic [21:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hif.line_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset", obs(), IDLE_W);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // t2: second request cycle (-1 none); ovf expected in [of,ot]
  task automatic run(input string tag, input int n,
                     input int r0, input int r1, input int t2,
                     input int rst_at, input int of,
                     input int ot);
    int rel;
    logic [21:0] exp;
    for (int k = 0; k < n; k++) begin
      hif.line_req = (k == r0 || k == r1 || k == t2);
      rst = (k == rst_at);
      @(negedge clk);
      rel = (t2 >= 0 && k > t2) ? k - t2 : k - r0;
      exp = mdl(rel, k >= of && k <= ot);
      if (rst_at >= 0 && k > rst_at) exp = IDLE_W;
      check($sformatf("%s@%0d", tag, k), obs(), exp);
      @(posedge clk); #1;
    end
    hif.line_req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b1;
    hif.line_req = 1'b0;
    @(posedge clk); #1;
    do_reset();
    run("line", 42, 0, -1, -1, -1, 1, 0);
    do_reset();
    run("ovf", 45, 0, 10, -1, -1, 11, 1000);
    do_reset();
    run("b2b", 78, 0, -1, 34, -1, 1, 0);
    do_reset();
    run("rst", 45, 0, 5, -1, 20, 6, 20);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
